// File: rtl/riscv_pkg.sv
// Shared load/store definitions: Funct3 access codes, LSU state enum and
// small decode helpers used by the memory-stage load/store unit.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  function automatic logic isLegalLoad(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic isLegalStore(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // Size lives in f3[1:0] for both loads and stores (bit 2 is only the sign).
  function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] addrLo);
    case (f3[1:0])
      2'b01:   return addrLo[0];
      2'b10:   return |addrLo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane selection and sign/zero extension of a 32-bit memory word.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addrLo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addrLo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addrLo[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_word;
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LHU:  o_data = {16'h0, w_half};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/ack data port, byte enables, load extension, stall.
// Optional misaligned-access trap when LSU_MISALIGN_TRAP_EN is defined.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic              EnM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              MisalignM
);

  lsu_state_t        r_state;
  logic [ADDR_W-1:0] r_memAddr;
  logic [31:0]       r_memWdata;
  logic [3:0]        r_memBe;
  logic              r_memWe;
  logic [2:0]        r_funct3;
  logic [1:0]        r_laneLo;
  logic [31:0]       r_ReadDataM;

  logic              w_present;
  logic              w_legal;
  logic              w_misalign;
  logic              w_access;
  logic              w_drive;
  logic              w_ack;
  logic              w_isLoad;
  logic [ADDR_W-1:0] w_issueAddr;
  logic [3:0]        w_issueBe;
  logic [31:0]       w_issueWdata;
  logic [2:0]        w_curFunct3;
  logic [1:0]        w_curLane;
  logic [31:0]       w_extData;

  assign w_present   = MemReadM | MemWriteM;
  assign w_legal     = MemWriteM ? isLegalStore(Funct3M) : isLegalLoad(Funct3M);
  assign w_access    = w_present & w_legal & ~w_misalign;
  assign w_issueAddr = {ALUResultM[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = w_present & w_legal & isMisaligned(Funct3M, ALUResultM[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_issueBe    = 4'b1111;
    w_issueWdata = 32'h0;
    if (MemWriteM) begin
      case (Funct3M)
        F3_SB: begin
          w_issueBe    = 4'b0001 << ALUResultM[1:0];
          w_issueWdata = {4{WriteDataM[7:0]}};
        end
        F3_SH: begin
          w_issueBe    = ALUResultM[1] ? 4'b1100 : 4'b0011;
          w_issueWdata = {2{WriteDataM[15:0]}};
        end
        default: w_issueWdata = WriteDataM;
      endcase
    end
  end

  // IDLE drives the port straight from the pipeline; BUSY replays the captured copy.
  always_comb begin
    w_drive     = ~rst & (((r_state == IDLE) & w_access) | (r_state == BUSY));
    mem_req     = w_drive;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = 4'b0000;
    mem_wdata   = 32'h0;
    w_curFunct3 = Funct3M;
    w_curLane   = ALUResultM[1:0];
    w_isLoad    = ~MemWriteM;
    if (r_state == BUSY) begin
      w_curFunct3 = r_funct3;
      w_curLane   = r_laneLo;
      w_isLoad    = ~r_memWe;
    end
    if (w_drive) begin
      if (r_state == BUSY) begin
        mem_we    = r_memWe;
        mem_addr  = r_memAddr;
        mem_be    = r_memBe;
        mem_wdata = r_memWdata;
      end else begin
        mem_we    = MemWriteM;
        mem_addr  = w_issueAddr;
        mem_be    = w_issueBe;
        mem_wdata = w_issueWdata;
      end
    end
  end

  assign w_ack     = w_drive & mem_ack;
  assign StallM    = ~rst & w_access & (r_state != DONE);
  assign ReadDataM = r_ReadDataM;

  load_extend u_loadExtend (
    .i_word   (mem_rdata),
    .i_addrLo (w_curLane),
    .i_funct3 (w_curFunct3),
    .o_data   (w_extData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_memAddr   <= '0;
      r_memWdata  <= 32'h0;
      r_memBe     <= 4'b0000;
      r_memWe     <= 1'b0;
      r_funct3    <= 3'b000;
      r_laneLo    <= 2'b00;
      r_ReadDataM <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            r_memAddr  <= w_issueAddr;
            r_memBe    <= w_issueBe;
            r_memWdata <= w_issueWdata;
            r_memWe    <= MemWriteM;
            r_funct3   <= Funct3M;
            r_laneLo   <= ALUResultM[1:0];
            r_state    <= mem_ack ? DONE : BUSY;
          end
        end
        BUSY:    if (mem_ack) r_state <= DONE;
        DONE:    if (EnM) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Illegal or trapped accesses leave a zero result behind.
      if (w_ack && w_isLoad)
        r_ReadDataM <= w_extData;
      else if ((r_state == IDLE) && w_present && (!w_legal || w_misalign))
        r_ReadDataM <= 32'h0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_MisalignM;
  logic r_trapHeld;

  // r_trapHeld keeps a frozen trapping instruction from pulsing more than once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_MisalignM <= 1'b0;
      r_trapHeld  <= 1'b0;
    end else begin
      r_MisalignM <= w_misalign & (r_state == IDLE) & ~r_trapHeld;
      r_trapHeld  <= w_misalign & (r_state == IDLE) & ~EnM;
    end
  end

  assign MisalignM = r_MisalignM;
`else
  assign MisalignM = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses
// compared against an arithmetic reference model of the load/store rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM, EnM, mem_ack;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, mem_rdata;
  logic        mem_req, mem_we, StallM, MisalignM;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] lastRd = 32'h0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .EnM(EnM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ReadDataM(ReadDataM), .StallM(StallM),
    .MisalignM(MisalignM)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not end within time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: what the rules say a lane/enable/word should be.
  function automatic logic [31:0] modelRead(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * (addr % 4))) % 256;
    h = (word >> (8 * (addr & 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    return word;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] modelBe(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    if (!st) return 32'd15;
    case (f3)
      3'd0:    return 32'd1 << (addr % 4);
      3'd1:    return 32'd3 << (addr & 2);
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd % 256) * 32'h01010101;
      3'd1:    return (wd % 65536) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  // One complete access: request cycles with 'waits' stalls, 'doneHold' frozen DONE cycles, then advance.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input int waits, input int doneHold);
    int stalls;
    stalls = 0;
    @(negedge clk);
    MemReadM = ~st; MemWriteM = st; Funct3M = f3; ALUResultM = addr;
    WriteDataM = wd; EnM = 1'b0;
    for (int c = 0; c <= waits; c++) begin
      mem_ack   = (c == waits);
      mem_rdata = (c == waits) ? rd : $urandom;
      #1;
      if (StallM) stalls++;
      checkOutput("mem_req_active", {31'b0, mem_req}, 32'd1);
      if (c == waits) begin
        checkOutput("mem_addr", mem_addr, addr - (addr % 4));
        checkOutput("mem_be", {28'b0, mem_be}, modelBe(st, f3, addr));
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, st});
        if (st) checkOutput("mem_wdata", mem_wdata, modelWdata(f3, wd));
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    for (int h = 0; h < doneHold; h++) begin
      #1;
      checkOutput("done_no_req", {31'b0, mem_req}, 32'd0);
      checkOutput("done_no_stall", {31'b0, StallM}, 32'd0);
      @(negedge clk);
    end
    EnM = 1'b1;
    #1;
    checkOutput("stall_cycles", stalls, waits + 1);
    checkOutput("done_stall", {31'b0, StallM}, 32'd0);
    checkOutput("done_req", {31'b0, mem_req}, 32'd0);
    if (!st) lastRd = modelRead(f3, addr, rd);
    checkOutput("ReadDataM", ReadDataM, lastRd);
    @(posedge clk);
    #1;
    MemReadM = 1'b0; MemWriteM = 1'b0; EnM = 1'b0;
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  loadCodes[5];
    logic [2:0]  storeCodes[3];
    loadCodes  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    storeCodes = '{3'd0, 3'd1, 3'd2};

    rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; EnM = 1'b0; mem_ack = 1'b0;
    Funct3M = 3'd0; ALUResultM = 32'h0; WriteDataM = 32'h0; mem_rdata = 32'h0;
    #12;
    checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_be", {28'b0, mem_be}, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_rdata", ReadDataM, 32'h0);
    checkOutput("rst_misalign", {31'b0, MisalignM}, 32'd0);
    checkOutput("rst_stall", {31'b0, StallM}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0);
    checkOutput("LW_value", ReadDataM, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF1234, 0, 0);
    checkOutput("LB_value", ReadDataM, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF1234, 1, 0);
    checkOutput("LBU_value", ReadDataM, 32'h00000080);
    applyStimulus(1'b0, 3'd1, 32'h202, 32'h0, 32'h80FF1234, 0, 1);
    checkOutput("LH_value", ReadDataM, 32'hFFFF80FF);
    applyStimulus(1'b1, 3'd0, 32'h301, 32'h000000AB, 32'h0, 1, 0);
    applyStimulus(1'b1, 3'd1, 32'h302, 32'h00001234, 32'h0, 0, 2);

    // Ack with nothing outstanding must not disturb anything.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    #1;
    checkOutput("stray_ack_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkOutput("stray_ack_rdata", ReadDataM, lastRd);

    // Illegal load code: no request, result cleared.
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'b011; ALUResultM = 32'h40; EnM = 1'b1;
    #1;
    checkOutput("illegal_req", {31'b0, mem_req}, 32'd0);
    checkOutput("illegal_stall", {31'b0, StallM}, 32'd0);
    @(posedge clk);
    #1;
    MemReadM = 1'b0; EnM = 1'b0;
    lastRd = 32'h0;
    checkOutput("illegal_rdata", ReadDataM, 32'h0);

    // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 3'd2, 32'h80, 32'h0, 32'hCAFEF00D, 0, 0);
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'd2; ALUResultM = 32'h101; EnM = 1'b1;
    #1;
    checkOutput("misalign_req", {31'b0, mem_req}, 32'd0);
    checkOutput("misalign_stall", {31'b0, StallM}, 32'd0);
    checkOutput("misalign_pre", {31'b0, MisalignM}, 32'd0);
    @(posedge clk);
    #1;
    MemReadM = 1'b0; EnM = 1'b0;
    checkOutput("misalign_pulse", {31'b0, MisalignM}, 32'd1);
    lastRd = 32'h0;
    checkOutput("misalign_rdata", ReadDataM, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("misalign_end", {31'b0, MisalignM}, 32'd0);
`else
    applyStimulus(1'b0, 3'd2, 32'h101, 32'h0, 32'hCAFEF00D, 1, 0);
    checkOutput("misalign_off_value", ReadDataM, 32'hCAFEF00D);
    checkOutput("misalign_off_flag", {31'b0, MisalignM}, 32'd0);
`endif

    // Reset while the request is waiting in BUSY.
    applyStimulus(1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678, 0, 0);
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = 3'd2; ALUResultM = 32'h80; EnM = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("busy_req_held", {31'b0, mem_req}, 32'd1);
    rst = 1'b1; MemReadM = 1'b0;
    #1;
    checkOutput("rst_busy_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_busy_stall", {31'b0, StallM}, 32'd0);
    checkOutput("rst_busy_rdata", ReadDataM, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    lastRd = 32'h0;
    checkOutput("post_rst_req", {31'b0, mem_req}, 32'd0);
    checkOutput("post_rst_stall", {31'b0, StallM}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? storeCodes[$urandom_range(0, 2)] : loadCodes[$urandom_range(0, 4)];
      addr = $urandom % 32'h10000;
`ifdef LSU_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01) addr = addr - (addr % 2);
      if (f3[1:0] == 2'b10) addr = addr - (addr % 4);
`endif
      applyStimulus(st, f3, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
